// File: rtl/board_button_pio.sv
// Avalon-MM input PIO: synchronizes and filters board buttons, latches edges (W1C) and raises a maskable level irq.
// Reads take 1 cycle with no wait states; define BOARD_BUTTON_PIO_DEBOUNCE_EN to build the per-bit debounce counters.
module board_button_pio #(
  parameter int unsigned      WIDTH           = 4,
  parameter int unsigned      DEBOUNCE_CYCLES = 16,
  parameter int unsigned      EDGE_TYPE       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE     = WIDTH'(4'hF)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_nxt;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edge_set;
  logic [WIDTH-1:0] w1c;
  logic             wr;

  assign wr = chipselect & ~write_n;

`ifdef BOARD_BUTTON_PIO_DEBOUNCE_EN
  localparam int unsigned     CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt     [WIDTH];
  logic [CNT_W-1:0] cnt_nxt [WIDTH];

  // Any cycle that agrees with the filtered value restarts the count, so only an
  // uninterrupted run of DEBOUNCE_CYCLES differing samples is accepted.
  always_comb begin
    data_nxt = data_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_nxt[i] = '0;
      if (s2[i] != data_q[i]) begin
        if (cnt[i] == CNT_MAX) begin
          data_nxt[i] = s2[i];
        end else begin
          cnt_nxt[i] = cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < WIDTH; i++) begin
      if (reset) begin
        cnt[i] <= '0;
      end else begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end
`else
  logic unused_debounce_cfg;
  assign unused_debounce_cfg = (DEBOUNCE_CYCLES != 0);
  assign data_nxt            = s2;
`endif

  if (WIDTH < 32) begin : g_wdata_hi
    logic unused_wdata_hi;
    assign unused_wdata_hi = ^writedata[31:WIDTH];
  end

  assign rise     = ~data_q & data_nxt;
  assign fall     = data_q & ~data_nxt;
  assign edge_set = (EDGE_TYPE == 0) ? rise :
                    (EDGE_TYPE == 1) ? fall : (rise | fall);

  // A capture landing in the same cycle as a software clear survives.
  assign w1c = (wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1           <= RESET_VALUE;
      s2           <= RESET_VALUE;
      data_q       <= RESET_VALUE;
      irq_mask     <= '0;
      edge_capture <= '0;
      readdata     <= '0;
    end else begin
      s1           <= in_port;
      s2           <= s1;
      data_q       <= data_nxt;
      edge_capture <= (edge_capture & ~w1c) | edge_set;
      if (wr && address == 2'd2) begin
        irq_mask <= writedata[WIDTH-1:0];
      end
      case (address)
        2'd0:    readdata <= 32'(data_q);
        2'd1:    readdata <= 32'(s2);
        2'd2:    readdata <= 32'(irq_mask);
        default: readdata <= 32'(edge_capture);
      endcase
    end
  end

  assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_board_button_pio.sv
// Directed bench for board_button_pio: reset, press, glitch, W1C, set/clear collision, reset mid-count.
module tb_board_button_pio;

  localparam int DB = 4;
`ifdef BOARD_BUTTON_PIO_DEBOUNCE_EN
  localparam int EFF = DB;
`else
  localparam int EFF = 1;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] readdata;
  logic        irq;
  logic [31:0] rd;

  int n_vec  = 0;
  int n_miss = 0;

  board_button_pio #(
    .WIDTH           (4),
    .DEBOUNCE_CYCLES (DB),
    .EDGE_TYPE       (1),
    .RESET_VALUE     (4'hF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    tick();
    d          = readdata;
    chipselect = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  initial begin
    reset      = 1'b1;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 4'hF;

    // Reset state
    repeat (3) tick();
    chk("rst_readdata", readdata, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    reset = 1'b0;
    bus_read(2'd0, rd); chk("rst_data", rd, 32'hF);
    bus_read(2'd1, rd); chk("rst_sync", rd, 32'hF);
    bus_read(2'd2, rd); chk("rst_mask", rd, 32'h0);
    bus_read(2'd3, rd); chk("rst_cap", rd, 32'h0);
    chk("rst_irq_after", {31'b0, irq}, 32'h0);

    // Clean press of bit 0: data_q updates on edge 2+EFF, visible in readdata one edge later
    tick();
    in_port = 4'hE;
    address = 2'd0;
    repeat (2 + EFF) tick();
    chk("press_before", readdata, 32'hF);
    tick();
    chk("press_data", readdata, 32'hE);
    bus_read(2'd3, rd); chk("press_cap", rd, 32'h1);
    chk("press_irq_masked", {31'b0, irq}, 32'h0);
    bus_write(2'd2, 32'h1);
    chk("press_irq_unmasked", {31'b0, irq}, 32'h1);

    // Bit 2 debounces on the same edge a W1C of bit 2 is written: the set must win
    tick();
    in_port = 4'hA;
    repeat (1 + EFF) tick();
    bus_write(2'd3, 32'h4);
    bus_read(2'd3, rd); chk("collide_cap", rd, 32'h5);

    // Write-1-to-clear
    bus_write(2'd2, 32'hF);
    chk("w1c_irq_init", {31'b0, irq}, 32'h1);
    bus_write(2'd3, 32'h4);
    chk("w1c_irq_partial", {31'b0, irq}, 32'h1);
    bus_read(2'd3, rd); chk("w1c_cap_partial", rd, 32'h1);
    bus_write(2'd3, 32'h1);
    chk("w1c_irq_cleared", {31'b0, irq}, 32'h0);
    bus_read(2'd3, rd); chk("w1c_cap_cleared", rd, 32'h0);

    // Three-cycle glitch on bit 1: visible at address 1, rejected by the filter when debouncing
    tick();
    in_port = 4'h8;
    address = 2'd1;
    repeat (3) tick();
    chk("glitch_sync_a", readdata, 32'h8);
    in_port = 4'hA;
    tick();
    chk("glitch_sync_b", readdata, 32'h8);
    repeat (8) tick();
    bus_write(2'd0, 32'h0);
    bus_read(2'd0, rd); chk("glitch_data", rd, 32'hA);
    bus_read(2'd3, rd); chk("glitch_cap", rd, (EFF == 1) ? 32'h2 : 32'h0);
    chk("glitch_irq", {31'b0, irq}, (EFF == 1) ? 32'h1 : 32'h0);
    bus_write(2'd3, 32'h2);

    // Reset while bit 3 is mid-count; filter restarts from RESET_VALUE
    tick();
    in_port = 4'h2;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_readdata", readdata, 32'h0);
    chk("midrst_irq", {31'b0, irq}, 32'h0);
    address = 2'd3;
    tick();
    chk("midrst_cap", readdata, 32'h0);
    address = 2'd0;
    repeat (EFF + 1) tick();
    chk("midrst_before", readdata, 32'hF);
    tick();
    chk("midrst_data", readdata, 32'h2);
    bus_read(2'd3, rd); chk("midrst_cap_after", rd, 32'hD);
    chk("midrst_irq_after", {31'b0, irq}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
